// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low row, samples synchronized columns,
// classifies each 4-row frame and debounces presses/releases over whole frames.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int             SW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_LAST   = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_REL} state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [3:0]    cand, cand_d;
  logic [3:0]    col_meta, col_sync;
  logic [SW-1:0] slot;
  logic [1:0]    row;
  logic          sample, frame_end;
  logic [1:0]    hits;
  logic [3:0]    hit_code;
  logic [2:0]    row_cnt, sum;
  logic [1:0]    row_col;
  logic          f_none, f_single;
  logic [3:0]    f_code;
  logic          valid_d;
  logic [3:0]    code_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
      row  <= 2'd0;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      row  <= row + 2'd1;
    end else begin
      slot <= slot + SW'(1);
    end
  end

  assign row_out   = ~(4'b0001 << row);
  assign sample    = (slot == SLOT_LAST);
  assign frame_end = sample && (row == 2'd3);

  // Per-row low-bit count; the frame total saturates at 2 since only "many" matters.
  always_comb begin
    row_cnt = 3'd0;
    row_col = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col_sync[c]) begin
        row_cnt = row_cnt + 3'd1;
        row_col = 2'(c);
      end
    end
    sum      = {1'b0, hits} + row_cnt;
    f_none   = (sum == 3'd0);
    f_single = (sum == 3'd1);
    f_code   = (row_cnt == 3'd1) ? {row, row_col} : hit_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits     <= 2'd0;
      hit_code <= 4'd0;
    end else if (sample) begin
      if (frame_end) begin
        hits <= 2'd0;
      end else begin
        hits <= (sum >= 3'd2) ? 2'd2 : sum[1:0];
        if (row_cnt == 3'd1 && hits == 2'd0) hit_code <= {row, row_col};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      cand  <= cand_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (f_single) begin
            cand_d = f_code;
            if (DB_LAST == 4'd1) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
            end else begin
              state_d = DB_PRESS;
              cnt_d   = 4'd1;
            end
          end
        end
        DB_PRESS: begin
          if (f_single && f_code == cand) begin
            if (cnt + 4'd1 == DB_LAST) begin
              state_d = PRESSED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = 4'd0;
          end
        end
        PRESSED: begin
          if (f_none) begin
            if (DB_LAST == 4'd1) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              state_d = DB_REL;
              cnt_d   = 4'd1;
            end
          end
        end
        DB_REL: begin
          if (f_none) begin
            if (cnt + 4'd1 == DB_LAST) begin
              state_d = IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt + 4'd1;
            end
          end else begin
            state_d = PRESSED;
            cnt_d   = 4'd0;
          end
        end
      endcase
    end
  end

  // A pulse is produced only on the transition into PRESSED from the press side.
  always_comb begin
    key_held = (state == PRESSED) || (state == DB_REL);
    valid_d  = frame_end && (state_d == PRESSED) &&
               ((state == IDLE) || (state == DB_PRESS));
    code_d   = valid_d ? cand_d : key_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
    end else begin
      key_valid <= valid_d;
      key_code  <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives col_in from row_out, and a
// frame-level streak model predicts pulses, held state and key code.
module tb_keypad_scanner;

  localparam int DB = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys;

  int n_cmp;
  int n_err;

  // reference model state
  bit         m_held;
  logic [3:0] m_code;
  int         m_run;
  int         m_cand;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_out(row_out),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // keypad: a pressed key shorts its column to the currently driven (low) row
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0;
    m_code = 4'd0;
    m_run  = 0;
    m_cand = -1;
  endtask

  // Frame-level rules: a streak of identical single-key frames accepts a press,
  // a streak of empty frames accepts a release; anything else breaks the streak.
  task automatic model_frame(input logic [15:0] mask, output bit pulse);
    int n;
    int code;
    n = $countones(mask);
    code = 0;
    for (int k = 0; k < 16; k++) if (mask[k]) code = k;
    pulse = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run == 0) begin
          m_cand = code;
          m_run  = 1;
        end else if (code == m_cand) begin
          m_run++;
        end else begin
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      if (m_run == DB) begin
        m_held = 1;
        m_code = 4'(m_cand);
        m_run  = 0;
        pulse  = 1;
      end
    end else begin
      if (n == 0) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        m_held = 0;
        m_run  = 0;
      end
    end
  endtask

  // driver: hold a key mask for one whole frame, checking row walk and outputs
  task automatic run_frame(input logic [15:0] mask);
    bit   exp_pulse;
    int   pulses;
    logic last_valid;
    logic [3:0] exp_row;
    keys = mask;
    pulses = 0;
    last_valid = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk);
      #1;
      exp_row = ~(4'b0001 << ((j / 4) % 4));
      check("row_out", row_out, exp_row);
      if (key_valid) pulses++;
      last_valid = key_valid;
    end
    model_frame(mask, exp_pulse);
    check("pulse_count", pulses, exp_pulse ? 1 : 0);
    check("valid_at_end", last_valid, exp_pulse);
    check("key_held", key_held, m_held);
    check("key_code", key_code, m_code);
  endtask

  task automatic run_frames(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) run_frame(mask);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_held", key_held, 1'b0);
    check("rst_key_code", key_code, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_row_out", row_out, 4'b1110);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] key(input int k);
    logic [15:0] m;
    m = 16'd1 << k;
    return m;
  endfunction

  initial begin
    logic [15:0] cur;
    int a;
    int b;
    n_cmp = 0;
    n_err = 0;
    keys  = 16'h0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("init_row_out", row_out, 4'b1110);
    check("init_key_valid", key_valid, 1'b0);
    check("init_key_held", key_held, 1'b0);
    check("init_key_code", key_code, 4'd0);
    rst_n = 1'b1;

    // idle sweep
    run_frames(16'h0, 4);
    // clean press of key 9 and release; code sticks at 9
    run_frames(key(9), 5);
    run_frames(16'h0, 4);
    // bounce on key 5
    run_frames(key(5), 2);
    run_frame(16'h0);
    run_frames(key(5), 3);
    run_frames(16'h0, 3);
    // multi-key from idle, then rollover while held
    run_frames(key(0) | key(15), 4);
    run_frame(16'h0);
    run_frames(key(3), 3);
    run_frames(key(3) | key(12), 3);
    run_frames(16'h0, 3);
    // key change without release
    run_frames(key(7), 3);
    run_frames(key(8), 4);
    run_frames(16'h0, 3);
    run_frames(key(8), 3);
    run_frames(16'h0, 3);
    // reset mid-debounce, then mid-held, with the key still down
    run_frames(key(9), 2);
    pulse_reset();
    run_frames(key(9), 4);
    pulse_reset();
    run_frames(key(9), 4);
    run_frames(16'h0, 3);

    // randomized frames: masks persist for a while so presses can debounce
    cur = 16'h0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 99) < 35) begin
        a = $urandom_range(0, 99);
        if (a < 40) begin
          cur = 16'h0;
        end else if (a < 85) begin
          cur = key($urandom_range(0, 15));
        end else begin
          a = $urandom_range(0, 15);
          b = (a + $urandom_range(1, 15)) % 16;
          cur = key(a) | key(b);
        end
      end
      run_frame(cur);
    end
    run_frames(16'h0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
